vreg_port_sched: RTL

Access scheduler for the eight-entry 16×16-bit vector register file. It arbitrates between two requesters and drives the register file's address and read/write strobes:
- the vector ALU, which needs single-cycle parallel (256-bit) reads and writes;
- the load/store unit, which streams 16-element serial bursts.

It sequences each serial burst element by element and reports progress back to the requester. Only one operation owns the register file at a time.

---
 rtl/vreg_pkg.sv | 14 +
 rtl/vreg_rr_arb.sv | 18 +
 rtl/vreg_port_sched.sv | 82 ++++++++
 3 files changed

// File: rtl/vreg_pkg.sv
// vreg_pkg: shared sizes, scheduler state encoding and op codes for the vector register file scheduler
package vreg_pkg;
  localparam int NUM_VREG = 8;
  localparam int NUM_ELEM = 16;
  localparam int ADDR_W   = 3;
  localparam int EIDX_W   = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAR  = 2'd1,
    SER  = 2'd2
  } state_t;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/vreg_rr_arb.sv
// vreg_rr_arb: two-requester round-robin arbiter owning the last-served flag
module vreg_rr_arb (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_p,
  input  logic i_req_s,
  output logic o_win_p,
  output logic o_win_s
);
  logic r_last_s;
  assign o_win_p = i_en & i_req_p & (~i_req_s | r_last_s);
  assign o_win_s = i_en & i_req_s & (~i_req_p | ~r_last_s);
  // remember who was served last; starts as serial so parallel wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_last_s <= 1'b1;
    else if (o_win_p | o_win_s) r_last_s <= o_win_s;
endmodule

// File: rtl/vreg_port_sched.sv
// vreg_port_sched: register-file access scheduler for ALU parallel and LSU serial requests (VREG_SCHED_B2B_EN enables back-to-back handover)
module vreg_port_sched
  import vreg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_p,
  input  logic              i_op_p,
  input  logic [ADDR_W-1:0] i_addr_p,
  input  logic [ADDR_W-1:0] i_addr2_p,
  output logic              o_gnt_p,
  input  logic              i_req_s,
  input  logic              i_op_s,
  input  logic [ADDR_W-1:0] i_addr_s,
  input  logic [ADDR_W-1:0] i_addr2_s,
  output logic              o_gnt_s,
  output logic              o_valid_s,
  output logic [EIDX_W-1:0] o_elem_s,
  output logic              o_done_s,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_vaddr,
  output logic [ADDR_W-1:0] o_vaddr2,
  output logic              o_vrd_p,
  output logic              o_vwr_p,
  output logic              o_vrd_s,
  output logic              o_vwr_s
);
  state_t            r_state;
  logic [EIDX_W-1:0] r_cnt;
  logic              r_op;
  logic [ADDR_W-1:0] r_vaddr;
  logic [ADDR_W-1:0] r_vaddr2;
  logic              w_last;
  logic              w_arb_en;
  logic              w_win_p;
  logic              w_win_s;
  logic              w_par;
  logic              w_ser;
  assign w_par  = (r_state == PAR);
  assign w_ser  = (r_state == SER);
  assign w_last = w_ser && (r_cnt == EIDX_W'(NUM_ELEM - 1));
`ifdef VREG_SCHED_B2B_EN
  assign w_arb_en = (r_state == IDLE) || w_par || w_last;
`else
  assign w_arb_en = (r_state == IDLE);
`endif
  vreg_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_arb_en),
    .i_req_p (i_req_p),
    .i_req_s (i_req_s),
    .o_win_p (w_win_p),
    .o_win_s (w_win_s)
  );
  // state, element counter and captured op/addresses; counter wraps to 0 after the last element
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= OP_RD;
      r_vaddr  <= '0;
      r_vaddr2 <= '0;
    end else begin
      r_cnt   <= w_ser ? r_cnt + 1'b1 : '0;
      r_state <= w_win_p ? PAR : w_win_s ? SER : (w_par || w_last) ? IDLE : r_state;
      if (w_win_p) {r_op, r_vaddr, r_vaddr2} <= {i_op_p, i_addr_p, i_addr2_p};
      else if (w_win_s) {r_op, r_vaddr, r_vaddr2} <= {i_op_s, i_addr_s, i_addr2_s};
    end
  assign o_gnt_p   = w_par;
  assign o_vrd_p   = w_par & (r_op == OP_RD);
  assign o_vwr_p   = w_par & (r_op == OP_WR);
  assign o_valid_s = w_ser;
  assign o_vrd_s   = w_ser & (r_op == OP_RD);
  assign o_vwr_s   = w_ser & (r_op == OP_WR);
  assign o_gnt_s   = w_ser && (r_cnt == '0);
  assign o_done_s  = w_last;
  assign o_elem_s  = r_cnt;
  assign o_busy    = (r_state != IDLE);
  assign o_vaddr   = r_vaddr;
  assign o_vaddr2  = r_vaddr2;
endmodule
